// File: rtl/fifo_wb_drain_pkg.sv
// Shared definitions for the Wishbone FIFO drain engine: state encoding,
// slave register map, STATUS field layout and the bus-timeout length.
// The optional bus timeout is enabled with FIFO_WB_DRAIN_TIMEOUT_EN.
package fifo_wb_drain_pkg;

    // State encoding kept as plain constants for compatibility with older tools.
    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_POLL      = 3'd1;
    localparam state_t S_POLL_WAIT = 3'd2;
    localparam state_t S_READ      = 3'd3;
    localparam state_t S_READ_WAIT = 3'd4;
    localparam state_t S_OUT       = 3'd5;
    localparam state_t S_GAP       = 3'd6;
    localparam state_t S_ERROR     = 3'd7;

    // Byte offsets of the downstream FIFO slave registers.
    localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFS_STATUS = 32'h0000_0004;

    // STATUS register layout: empty flag and fill level.
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_LEVEL_LSB = 16;
    localparam int STAT_LEVEL_MSB = 31;

    // Number of wait-state cycles tolerated before a missing response is an error.
    localparam int TIMEOUT_CYCLES = 256;

    // A STATUS word announces data only when the level is non-zero and empty is clear.
    function automatic logic status_has_data(input logic [31:0] status);
        return (status[STAT_LEVEL_MSB:STAT_LEVEL_LSB] != 16'd0) && !status[STAT_EMPTY_BIT];
    endfunction

endpackage

// File: rtl/fifo_wb_drain_obuf.sv
// One-entry output holding register with valid/ready handshake. The word
// captured on load_i is presented until the consumer accepts it.
module fifo_wb_drain_obuf
    import fifo_wb_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // Capture a new word on load, release it on a stream handshake.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            data_q  <= {DATA_WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_wb_drain.sv
// Wishbone master that drains a memory-mapped FIFO slave into a stream.
// It polls STATUS, reads DATA once per announced word and forwards each
// word through a one-entry output buffer. Only one bus cycle is ever
// outstanding. Define FIFO_WB_DRAIN_TIMEOUT_EN to turn a silent slave
// into a bus error after TIMEOUT_CYCLES wait cycles.
module fifo_wb_drain
    import fifo_wb_drain_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
    parameter int                    POLL_GAP   = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    enable_i,
    output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
    input  logic [DATA_WIDTH-1:0]   m_wb_dat_i,
    output logic                    m_wb_we_o,
    output logic [DATA_WIDTH/8-1:0] m_wb_sel_o,
    output logic                    m_wb_cyc_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i,
    input  logic                    m_wb_err_i,
    input  logic                    m_wb_stall_i,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    err_o,
    output logic [31:0]             count_o
);

    localparam int                    SEL_W      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADR_STATUS = BASE_ADDR + ADDR_WIDTH'(OFS_STATUS);
    localparam logic [ADDR_WIDTH-1:0] ADR_DATA   = BASE_ADDR + ADDR_WIDTH'(OFS_DATA);
    localparam logic [15:0]           GAP_LAST   = 16'(POLL_GAP - 1);

    state_t                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    err_q, err_d;
    logic [31:0]             count_q, count_d;
    logic [15:0]             rem_q, rem_d;
    logic [15:0]             gap_q, gap_d;
    logic                    load_s;
    logic                    hs_s;
    logic                    tmo_s;
    logic                    bus_err_s;
    logic                    tvalid_s;
    logic [DATA_WIDTH-1:0]   tdata_s;

`ifdef FIFO_WB_DRAIN_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic       wait_s;
    logic [7:0] tmo_q, tmo_d;

    assign wait_s = (state_q == S_POLL_WAIT) || (state_q == S_READ_WAIT);
    assign tmo_s  = wait_s && !m_wb_ack_i && (tmo_q == TMO_LAST);

    // Count consecutive wait cycles without a slave response.
    always_comb begin
        tmo_d = 8'd0;
        if (wait_s && !m_wb_ack_i && !m_wb_err_i) begin
            tmo_d = tmo_q + 8'd1;
        end else begin
            tmo_d = 8'd0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    assign bus_err_s = m_wb_err_i | tmo_s;
    assign hs_s      = tvalid_s & m_tready;

    // Master FSM: sequences STATUS polls, DATA reads and stream hand-off.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        err_d   = err_q;
        count_d = count_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        load_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_POLL;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = ADR_STATUS;
                end else begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                end
            end

            S_POLL: begin
                // The request is raised on entry; it is accepted once stall is low.
                if (!m_wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = S_POLL_WAIT;
                end else begin
                    stb_d = 1'b1;
                end
            end

            S_POLL_WAIT: begin
                if (bus_err_s) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else if (m_wb_ack_i) begin
                    cyc_d = 1'b0;
                    rem_d = m_wb_dat_i[STAT_LEVEL_MSB:STAT_LEVEL_LSB];
                    gap_d = 16'd0;
                    if (status_has_data(m_wb_dat_i[31:0])) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cyc_d = 1'b1;
                end
            end

            S_READ: begin
                // Coming from a STATUS ack the bus is idle for one cycle first.
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    adr_d = ADR_DATA;
                end else if (!m_wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = S_READ_WAIT;
                end else begin
                    stb_d = 1'b1;
                end
            end

            S_READ_WAIT: begin
                if (bus_err_s) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else if (m_wb_ack_i) begin
                    cyc_d   = 1'b0;
                    load_s  = 1'b1;
                    state_d = S_OUT;
                end else begin
                    cyc_d = 1'b1;
                end
            end

            S_OUT: begin
                // The next DATA read starts only on the edge that empties the buffer.
                if (hs_s) begin
                    count_d = count_q + 32'd1;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q > 16'd1) begin
                        state_d = S_READ;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        adr_d   = ADR_DATA;
                    end else if (enable_i) begin
                        state_d = S_POLL;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        adr_d   = ADR_STATUS;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_OUT;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = 16'd0;
                    if (enable_i) begin
                        state_d = S_POLL;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        adr_d   = ADR_STATUS;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            S_ERROR: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                if (!enable_i) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase

        if (cyc_d) begin
            sel_d = {SEL_W{1'b1}};
        end else begin
            sel_d = {SEL_W{1'b0}};
        end
    end

    // State and registered bus outputs; reset drops the bus immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            adr_q   <= {ADDR_WIDTH{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            err_q   <= 1'b0;
            count_q <= 32'd0;
            rem_q   <= 16'd0;
            gap_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
        end
    end

    fifo_wb_drain_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load_i   (load_s),
        .data_i   (m_wb_dat_i),
        .data_o   (tdata_s),
        .valid_o  (tvalid_s),
        .ready_i  (m_tready)
    );

    assign m_wb_adr_o = adr_q;
    assign m_wb_we_o  = 1'b0;
    assign m_wb_sel_o = sel_q;
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = stb_q;
    assign m_tdata    = tdata_s;
    assign m_tvalid   = tvalid_s;
    assign err_o      = err_q;
    assign count_o    = count_q;

endmodule
